axi_mem_responder: RTL and testbench

AXI4 slave backed by an internal word array. It answers the data-cache master's read and write bursts (64-bit beats, cache-line INCR bursts) in simulation and FPGA builds. The read and write channels run independently, one outstanding transaction per direction.

---
 rtl/axi_mem_responder_pkg.sv | 26 ++
 rtl/axi_burst_addr_gen.sv | 25 ++
 rtl/axi_mem_responder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_responder_pkg.sv
// Shared encodings for the AXI memory responder: burst types, response codes,
// the only supported beat size, and the read/write FSM state types.
package axi_mem_responder_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // log2 of bytes per beat for 64-bit beats
    localparam logic [2:0] SIZE_64 = 3'd3;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rstate_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for an AXI burst.
//   addr_i      current beat byte address
//   burst_i     burst type (FIXED holds, INCR advances, WRAP treated as INCR)
//   size_i      log2 bytes per beat
//   next_addr_o address of the following beat
module axi_burst_addr_gen
    import axi_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]            burst_i,
    input  logic [2:0]            size_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    always_comb begin
        next_addr_o = addr_i + (ADDR_WIDTH'(1) << size_i);
        // Reserved encoding and WRAP both fall through to INCR behaviour.
        if (burst_i == BURST_FIXED) begin
            next_addr_o = addr_i;
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal word array. Read and write channels run
// independently with one outstanding transaction per direction.
//   clk, reset        rising-edge clock, synchronous active-high reset
//   s_axi_aw*/w*/b*   write address, data and response channels
//   s_axi_ar*/r*      read address and data channels
// All outputs are forced to 0 while reset is high. Memory is never reset.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 13,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> 3) < ADDR_WIDTH'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = (a - BASE_ADDR) >> 3;
        return IDX_W'(off);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    // ---------------- read channel ----------------
    rstate_e               rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_next;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
    logic                  rerr_q, rerr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ar_hs, r_hs, fetch, fetch_err;
    logic [ADDR_WIDTH-1:0] fetch_addr;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr_gen (
        .addr_i      (raddr_q),
        .burst_i     (rburst_q),
        .size_i      (SIZE_64),
        .next_addr_o (raddr_next)
    );

    assign s_axi_arready = !reset && (rstate_q == R_IDLE);
    assign s_axi_rvalid  = !reset && (rstate_q == R_BURST);
    assign s_axi_rid     = reset ? '0 : rid_q;
    assign s_axi_rdata   = reset ? '0 : rdata_q;
    assign s_axi_rresp   = reset ? RESP_OKAY : rresp_q;
    assign s_axi_rlast   = s_axi_rvalid && (rcnt_q == rlen_q);
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign r_hs          = s_axi_rvalid && s_axi_rready;

    // Read data is registered one beat ahead, so it stays stable through
    // stalls and a same-cycle write to the word is not seen (read-before-write).
    always_comb begin
        rstate_d   = rstate_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rburst_d   = rburst_q;
        rerr_d     = rerr_q;
        rcnt_d     = rcnt_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        fetch      = 1'b0;
        fetch_addr = raddr_next;
        fetch_err  = rerr_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rid_d      = s_axi_arid;
                    raddr_d    = s_axi_araddr;
                    rlen_d     = s_axi_arlen;
                    rburst_d   = s_axi_arburst;
                    rerr_d     = (s_axi_arsize != SIZE_64);
                    rcnt_d     = 8'd0;
                    fetch      = 1'b1;
                    fetch_addr = s_axi_araddr;
                    fetch_err  = (s_axi_arsize != SIZE_64);
                    rstate_d   = R_BURST;
                end
            end
            R_BURST: begin
                if (r_hs) begin
                    if (rcnt_q == rlen_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rcnt_d  = rcnt_q + 8'd1;
                        raddr_d = raddr_next;
                        fetch   = 1'b1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        if (fetch) begin
            if (!fetch_err && in_range(fetch_addr)) begin
                rdata_d = mem_q[word_idx(fetch_addr)];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rburst_q <= '0;
            rerr_q   <= 1'b0;
            rcnt_q   <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rburst_q <= rburst_d;
            rerr_q   <= rerr_d;
            rcnt_q   <= rcnt_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    // ---------------- write channel ----------------
    wstate_e               wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, waddr_next;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  werr_q, werr_d;
    logic                  aw_hs, w_hs, mem_we, beat_last;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr_gen (
        .addr_i      (waddr_q),
        .burst_i     (wburst_q),
        .size_i      (SIZE_64),
        .next_addr_o (waddr_next)
    );

    assign s_axi_awready = !reset && (wstate_q == W_IDLE);
    assign s_axi_wready  = !reset && (wstate_q == W_DATA);
    assign s_axi_bvalid  = !reset && (wstate_q == W_RESP);
    assign s_axi_bid     = reset ? '0 : wid_q;
    assign s_axi_bresp   = (!reset && werr_q) ? RESP_SLVERR : RESP_OKAY;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;
    assign beat_last     = (wcnt_q == wlen_q);

    always_comb begin
        wstate_d = wstate_q;
        wid_d    = wid_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wburst_d = wburst_q;
        werr_d   = werr_q;
        wcnt_d   = wcnt_q;
        mem_we   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    wid_d    = s_axi_awid;
                    waddr_d  = s_axi_awaddr;
                    wlen_d   = s_axi_awlen;
                    wburst_d = s_axi_awburst;
                    werr_d   = (s_axi_awsize != SIZE_64);
                    wcnt_d   = 8'd0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (werr_q || !in_range(waddr_q)) begin
                        werr_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                    // Either wlast or the beat count closes the burst; a
                    // disagreement between them is reported as SLVERR.
                    if (s_axi_wlast || beat_last) begin
                        if (s_axi_wlast != beat_last) begin
                            werr_d = 1'b1;
                        end
                        wstate_d = W_RESP;
                    end else begin
                        wcnt_d  = wcnt_q + 8'd1;
                        waddr_d = waddr_next;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q <= W_IDLE;
            wid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wburst_q <= '0;
            werr_q   <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            wstate_q <= wstate_d;
            wid_q    <= wid_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wburst_q <= wburst_d;
            werr_q   <= werr_d;
            wcnt_q   <= wcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem_q[word_idx(waddr_q)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: a table of write/read bursts
// checked against a bench-side memory model through R and B scoreboards,
// plus a hand-written reset-in-mid-burst sequence.
module tb_axi_mem_responder;
    import axi_mem_responder_pkg::*;

    localparam int          ID_W = 13;
    localparam int          MW   = 1024;
    localparam logic [63:0] BASE = 64'h1000;
    localparam int          NVEC = 21;

    logic        clk, reset;
    logic [12:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [63:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
    logic [7:0]  s_axi_awlen, s_axi_arlen, s_axi_wstrb;
    logic [2:0]  s_axi_awsize, s_axi_arsize;
    logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

    axi_mem_responder #(
        .ID_WIDTH   (ID_W),
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .MEM_WORDS  (MW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [12:0] id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [7:0]  strb;
        logic [63:0] data;       // beat i carries data + i
        int          wlast_beat; // beat index that carries wlast
        logic [1:0]  exp_bresp;
        bit          stall;      // toggle rready every cycle
        bit          chk_first;  // first read beat must equal exp_first
        logic [63:0] exp_first;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [12:0] id;
    } rbeat_t;

    typedef struct {
        logic [1:0]  resp;
        logic [12:0] id;
    } bresp_t;

    vec_t        vecs [NVEC];
    rbeat_t      r_exp [$];
    bresp_t      b_exp [$];
    logic [63:0] model [MW];
    int          tests_run = 0;
    int          tests_failed = 0;

    bit          stalled_prev = 0;
    logic [63:0] prev_data;
    logic [1:0]  prev_resp;
    logic        prev_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: got no handshake expected one within the cycle budget", name);
    endtask

    function automatic bit tb_in_range(input logic [63:0] a);
        return (a >= BASE) && (((a - BASE) >> 3) < 64'(MW));
    endfunction

    function automatic int tb_idx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic vec_t wr(input logic [12:0] id, input logic [63:0] addr,
                                input logic [7:0] len, input logic [1:0] burst,
                                input logic [2:0] size, input logic [7:0] strb,
                                input logic [63:0] data, input int wlb, input logic [1:0] br);
        vec_t v;
        v = '{is_wr: 1'b1, id: id, addr: addr, len: len, burst: burst, size: size,
              strb: strb, data: data, wlast_beat: wlb, exp_bresp: br, stall: 1'b0,
              chk_first: 1'b0, exp_first: 64'h0};
        return v;
    endfunction

    function automatic vec_t rd(input logic [12:0] id, input logic [63:0] addr,
                                input logic [7:0] len, input logic [1:0] burst,
                                input logic [2:0] size, input bit stall,
                                input bit cf, input logic [63:0] ef);
        vec_t v;
        v = '{is_wr: 1'b0, id: id, addr: addr, len: len, burst: burst, size: size,
              strb: 8'h0, data: 64'h0, wlast_beat: 0, exp_bresp: RESP_OKAY, stall: stall,
              chk_first: cf, exp_first: ef};
        return v;
    endfunction

    // Returns after the handshake edge (plus #1) or after the cycle budget.
    task automatic wait_hs(input int which, output bit ok);
        logic rdy;
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            rdy = (which == 0) ? s_axi_awready : (which == 1) ? s_axi_wready : s_axi_arready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_write(input vec_t v);
        logic [63:0] a;
        bit          ok;
        b_exp.push_back('{resp: v.exp_bresp, id: v.id});
        s_axi_awid    = v.id;
        s_axi_awaddr  = v.addr;
        s_axi_awlen   = v.len;
        s_axi_awsize  = v.size;
        s_axi_awburst = v.burst;
        s_axi_awvalid = 1'b1;
        wait_hs(0, ok);
        s_axi_awvalid = 1'b0;
        if (!ok) timeout("aw_handshake");
        a = v.addr;
        for (int b = 0; b <= v.wlast_beat; b++) begin
            s_axi_wdata  = v.data + 64'(b);
            s_axi_wstrb  = v.strb;
            s_axi_wlast  = (b == v.wlast_beat);
            s_axi_wvalid = 1'b1;
            wait_hs(1, ok);
            if (!ok) timeout("w_handshake");
            if (v.size == 3'd3 && tb_in_range(a)) begin
                for (int i = 0; i < 8; i++) begin
                    if (v.strb[i]) model[tb_idx(a)][8*i +: 8] = s_axi_wdata[8*i +: 8];
                end
            end
            if (v.burst != BURST_FIXED) a = a + 64'd8;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        for (int n = 0; n < 64 && b_exp.size() != 0; n++) @(posedge clk);
        #1;
        if (b_exp.size() != 0) begin
            timeout("b_response");
            b_exp.delete();
        end
    endtask

    task automatic start_read(input vec_t v);
        logic [63:0] a;
        rbeat_t      e;
        bit          ok, good;
        a = v.addr;
        for (int b = 0; b <= int'(v.len); b++) begin
            good   = (v.size == 3'd3) && tb_in_range(a);
            e.data = good ? model[tb_idx(a)] : 64'h0;
            e.resp = good ? RESP_OKAY : RESP_SLVERR;
            e.last = (b == int'(v.len));
            e.id   = v.id;
            if (b == 0 && v.chk_first) e.data = v.exp_first;
            r_exp.push_back(e);
            if (v.burst != BURST_FIXED) a = a + 64'd8;
        end
        s_axi_arid    = v.id;
        s_axi_araddr  = v.addr;
        s_axi_arlen   = v.len;
        s_axi_arsize  = v.size;
        s_axi_arburst = v.burst;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = !v.stall;
        wait_hs(2, ok);
        s_axi_arvalid = 1'b0;
        if (!ok) timeout("ar_handshake");
    endtask

    task automatic finish_read(input bit stall);
        for (int n = 0; n < 1200 && r_exp.size() != 0; n++) begin
            @(posedge clk);
            #1;
            s_axi_rready = stall ? !s_axi_rready : 1'b1;
        end
        if (r_exp.size() != 0) begin
            timeout("r_beats");
            r_exp.delete();
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        chk("rvalid_low_after_burst", 64'(s_axi_rvalid), 64'h0);
        @(posedge clk);
        #1;
    endtask

    // R and B scoreboards plus the stall-stability check.
    always @(negedge clk) begin : mon
        rbeat_t e;
        bresp_t eb;
        if (!reset) begin
            if (stalled_prev && s_axi_rvalid) begin
                chk("rdata_stable", s_axi_rdata, prev_data);
                chk("rresp_stable", 64'(s_axi_rresp), 64'(prev_resp));
                chk("rlast_stable", 64'(s_axi_rlast), 64'(prev_last));
            end
            stalled_prev = s_axi_rvalid && !s_axi_rready;
            prev_data    = s_axi_rdata;
            prev_resp    = s_axi_rresp;
            prev_last    = s_axi_rlast;
            if (s_axi_rvalid && s_axi_rready) begin
                if (r_exp.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL r_extra_beat: got beat data 0x%0h expected none", s_axi_rdata);
                end else begin
                    e = r_exp.pop_front();
                    chk("rdata", s_axi_rdata, e.data);
                    chk("rresp", 64'(s_axi_rresp), 64'(e.resp));
                    chk("rlast", 64'(s_axi_rlast), 64'(e.last));
                    chk("rid", 64'(s_axi_rid), 64'(e.id));
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (b_exp.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL b_extra: got bresp 0x%0h expected none", s_axi_bresp);
                end else begin
                    eb = b_exp.pop_front();
                    chk("bresp", 64'(s_axi_bresp), 64'(eb.resp));
                    chk("bid", 64'(s_axi_bid), 64'(eb.id));
                end
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = wr(13'h0A5, BASE + 64'h40, 8'd7, BURST_INCR, 3'd3, 8'hFF, 64'h1000, 7,
                      RESP_OKAY);
        vecs[1]  = rd(13'h123, BASE + 64'h40, 8'd7, BURST_INCR, 3'd3, 0, 1, 64'h1000);
        vecs[2]  = wr(13'h001, BASE + 64'h8, 8'd0, BURST_INCR, 3'd3, 8'hFF,
                      64'hFFFF_FFFF_FFFF_FFFF, 0, RESP_OKAY);
        vecs[3]  = wr(13'h002, BASE + 64'h8, 8'd0, BURST_INCR, 3'd3, 8'h0F, 64'h0, 0,
                      RESP_OKAY);
        vecs[4]  = rd(13'h003, BASE + 64'h8, 8'd0, BURST_INCR, 3'd3, 0, 1,
                      64'hFFFF_FFFF_0000_0000);
        vecs[5]  = rd(13'h004, BASE + 64'(MW * 8), 8'd1, BURST_INCR, 3'd3, 0, 1, 64'h0);
        vecs[6]  = wr(13'h005, BASE + 64'(MW * 8), 8'd0, BURST_INCR, 3'd3, 8'hFF, 64'hDEAD,
                      0, RESP_SLVERR);
        vecs[7]  = wr(13'h007, BASE + 64'((MW - 1) * 8), 8'd0, BURST_INCR, 3'd3, 8'hFF,
                      64'hABCD, 0, RESP_OKAY);
        vecs[8]  = rd(13'h006, BASE + 64'((MW - 1) * 8), 8'd1, BURST_INCR, 3'd3, 0, 1,
                      64'hABCD);
        vecs[9]  = rd(13'h008, BASE - 64'h8, 8'd0, BURST_INCR, 3'd3, 0, 1, 64'h0);
        vecs[10] = rd(13'h009, BASE + 64'h40, 8'd7, BURST_INCR, 3'd3, 1, 1, 64'h1000);
        vecs[11] = wr(13'h00A, BASE + 64'h200, 8'd3, BURST_INCR, 3'd3, 8'hFF, 64'h5000, 3,
                      RESP_OKAY);
        vecs[12] = wr(13'h00B, BASE + 64'h200, 8'd3, BURST_INCR, 3'd3, 8'hFF, 64'h2000, 1,
                      RESP_SLVERR);
        vecs[13] = rd(13'h00C, BASE + 64'h200, 8'd3, BURST_INCR, 3'd3, 0, 1, 64'h2000);
        vecs[14] = wr(13'h00D, BASE + 64'h300, 8'd0, BURST_INCR, 3'd2, 8'hFF, 64'h9999, 0,
                      RESP_SLVERR);
        vecs[15] = rd(13'h00E, BASE + 64'h300, 8'd0, BURST_INCR, 3'd2, 0, 1, 64'h0);
        vecs[16] = wr(13'h00F, BASE + 64'h100, 8'd2, BURST_FIXED, 3'd3, 8'hFF, 64'h7000, 2,
                      RESP_OKAY);
        vecs[17] = rd(13'h010, BASE + 64'h100, 8'd1, BURST_FIXED, 3'd3, 0, 1, 64'h7002);
        vecs[18] = rd(13'h011, BASE + 64'h40, 8'd7, BURST_WRAP, 3'd3, 0, 1, 64'h1000);
        vecs[19] = wr(13'h1FFF, BASE + 64'h800, 8'd255, BURST_INCR, 3'd3, 8'hFF, 64'h8000,
                      255, RESP_OKAY);
        vecs[20] = rd(13'h1ABC, BASE + 64'h800, 8'd255, BURST_INCR, 3'd3, 0, 1, 64'h8000);

        for (int i = 0; i < MW; i++) model[i] = 64'h0;

        reset         = 1'b1;
        s_axi_awid    = '0;
        s_axi_awaddr  = '0;
        s_axi_awlen   = '0;
        s_axi_awsize  = '0;
        s_axi_awburst = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wlast   = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_arid    = '0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arsize  = '0;
        s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(s_axi_awready), 64'h0);
        chk("rst_arready", 64'(s_axi_arready), 64'h0);
        chk("rst_bvalid", 64'(s_axi_bvalid), 64'h0);
        chk("rst_rvalid", 64'(s_axi_rvalid), 64'h0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        s_axi_wvalid = 1'b1;  // W before AW must not be accepted
        @(negedge clk);
        chk("post_rst_awready", 64'(s_axi_awready), 64'h1);
        chk("post_rst_arready", 64'(s_axi_arready), 64'h1);
        chk("wready_idle", 64'(s_axi_wready), 64'h0);
        @(posedge clk);
        #1;
        s_axi_wvalid = 1'b0;

        for (int k = 0; k < NVEC; k++) begin
            if (vecs[k].is_wr) begin
                do_write(vecs[k]);
            end else begin
                start_read(vecs[k]);
                finish_read(vecs[k].stall);
            end
        end

        // Reset in the middle of a read burst.
        start_read(rd(13'h0BB, BASE + 64'h40, 8'd7, BURST_INCR, 3'd3, 0, 0, 64'h0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_rvalid", 64'(s_axi_rvalid), 64'h0);
        chk("midrst_arready", 64'(s_axi_arready), 64'h0);
        r_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst_arready", 64'(s_axi_arready), 64'h1);
        chk("after_rst_rvalid", 64'(s_axi_rvalid), 64'h0);
        @(posedge clk);
        #1;
        start_read(rd(13'h0CC, BASE + 64'h40, 8'd7, BURST_INCR, 3'd3, 0, 1, 64'h1000));
        finish_read(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
